// File: rtl/draw_sequencer_pkg.sv
// Shared definitions for the board redraw sequencer: state encoding, grid geometry
// and bus widths.
package draw_sequencer_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StCardGo,
    StCardWait,
    StSymChk,
    StSymGo,
    StSymWait,
    StNext,
    StFin
  } state_e;

  // Board geometry in VGA pixels.
  localparam int unsigned GRID_X0    = 50;
  localparam int unsigned GRID_Y0    = 30;
  localparam int unsigned CELL_PITCH = 20;
  localparam int unsigned NUM_CELLS  = 9;

  localparam int unsigned IDX_W  = 4;
  localparam int unsigned CODE_W = 2;
  localparam int unsigned X_W    = 8;
  localparam int unsigned Y_W    = 7;
  localparam int unsigned COL_W  = 3;

endpackage

// File: rtl/draw_sequencer_cell_origin.sv
// Maps a row-major cell index (0..8) to the pixel origin of that cell on a 3x3 grid.
// Row/column come from range compares and offsets are constant multiples of the
// pitch, so no multiplier is built.
module cell_origin
  import draw_sequencer_pkg::*;
(
  input  logic [IDX_W-1:0] index,
  output logic [X_W-1:0]   cell_x,
  output logic [Y_W-1:0]   cell_y
);

  logic [1:0]       row;
  logic [IDX_W-1:0] col_full;
  logic [1:0]       col;

  // Split the index into row and column without a divider.
  always_comb begin
    row      = 2'd0;
    col_full = index;
    if (index >= IDX_W'(6)) begin
      row      = 2'd2;
      col_full = index - IDX_W'(6);
    end else if (index >= IDX_W'(3)) begin
      row      = 2'd1;
      col_full = index - IDX_W'(3);
    end
    col = col_full[1:0];
  end

  // Origin = grid base + 0, 1 or 2 pitches.
  always_comb begin
    unique case (col)
      2'd1:    cell_x = X_W'(GRID_X0 + CELL_PITCH);
      2'd2:    cell_x = X_W'(GRID_X0 + 2 * CELL_PITCH);
      default: cell_x = X_W'(GRID_X0);
    endcase
    unique case (row)
      2'd1:    cell_y = Y_W'(GRID_Y0 + CELL_PITCH);
      2'd2:    cell_y = Y_W'(GRID_Y0 + 2 * CELL_PITCH);
      default: cell_y = Y_W'(GRID_Y0);
    endcase
  end

endmodule

// File: rtl/draw_sequencer.sv
// Board redraw sequencer: launches the card-background engine once, then the symbol
// engine for every non-blank cell, muxing the active engine's pixel bus to the VGA
// adapter. A per-job watchdog aborts a redraw whose engine never answers.
module draw_sequencer
  import draw_sequencer_pkg::*;
#(
  parameter int unsigned WD_LIMIT = 4095
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          start,
  input  logic [NUM_CELLS*CODE_W-1:0]   sym_codes,
  output logic                          card_start,
  input  logic                          card_done,
  input  logic [X_W-1:0]                card_x,
  input  logic [Y_W-1:0]                card_y,
  input  logic [COL_W-1:0]              card_colour,
  input  logic                          card_we,
  output logic                          sym_start,
  output logic [CODE_W-1:0]             sym_sel,
  output logic [X_W-1:0]                sym_x,
  output logic [Y_W-1:0]                sym_y,
  input  logic                          sym_done,
  input  logic [X_W-1:0]                px_x,
  input  logic [Y_W-1:0]                px_y,
  input  logic [COL_W-1:0]              px_colour,
  input  logic                          px_we,
  output logic [X_W-1:0]                x,
  output logic [Y_W-1:0]                y,
  output logic [COL_W-1:0]              colour,
  output logic                          plot,
  output logic                          busy,
  output logic                          done,
  output logic                          error
);

  localparam int unsigned WdW = (WD_LIMIT < 1) ? 1 : $clog2(WD_LIMIT + 1);

  state_e                          state_q;
  logic [NUM_CELLS-1:0][CODE_W-1:0] codes_q;
  logic [IDX_W-1:0]                idx_q;
  logic [WdW-1:0]                  wd_q;
  logic                            card_start_q, sym_start_q, done_q, error_q;
  logic [CODE_W-1:0]               sym_sel_q;
  logic [X_W-1:0]                  sym_x_q, x_q;
  logic [Y_W-1:0]                  sym_y_q, y_q;
  logic [COL_W-1:0]                colour_q;
  logic                            plot_q;

  logic [CODE_W-1:0] cur_code;
  logic [X_W-1:0]    org_x;
  logic [Y_W-1:0]    org_y;
  logic              wd_hit;

  assign cur_code = codes_q[idx_q];
  assign wd_hit   = (wd_q == WdW'(WD_LIMIT));

  cell_origin u_cell_origin (
    .index  (idx_q),
    .cell_x (org_x),
    .cell_y (org_y)
  );

  // Sequencer FSM with registered control outputs; pulses default low each cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      codes_q      <= '0;
      idx_q        <= '0;
      wd_q         <= '0;
      card_start_q <= 1'b0;
      sym_start_q  <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      sym_sel_q    <= '0;
      sym_x_q      <= '0;
      sym_y_q      <= '0;
    end else begin
      card_start_q <= 1'b0;
      sym_start_q  <= 1'b0;
      done_q       <= 1'b0;
      case (state_q)
        StIdle: begin
          if (start) begin
            codes_q      <= sym_codes;
            idx_q        <= '0;
            error_q      <= 1'b0;
            card_start_q <= 1'b1;
            state_q      <= StCardGo;
          end
        end
        StCardGo: begin
          wd_q    <= '0;
          state_q <= StCardWait;
        end
        StCardWait: begin
          // A done pulse in the same cycle as the limit still counts as success.
          if (card_done) begin
            state_q <= StSymChk;
          end else if (wd_hit) begin
            error_q <= 1'b1;
            state_q <= StIdle;
          end else begin
            wd_q <= wd_q + 1'b1;
          end
        end
        StSymChk: begin
          if (cur_code == '0) begin
            state_q <= StNext;
          end else begin
            sym_start_q <= 1'b1;
            sym_sel_q   <= cur_code;
            sym_x_q     <= org_x;
            sym_y_q     <= org_y;
            state_q     <= StSymGo;
          end
        end
        StSymGo: begin
          wd_q    <= '0;
          state_q <= StSymWait;
        end
        StSymWait: begin
          if (sym_done) begin
            state_q <= StNext;
          end else if (wd_hit) begin
            error_q <= 1'b1;
            state_q <= StIdle;
          end else begin
            wd_q <= wd_q + 1'b1;
          end
        end
        StNext: begin
          if (idx_q == IDX_W'(NUM_CELLS - 1)) begin
            done_q  <= 1'b1;
            state_q <= StFin;
          end else begin
            idx_q   <= idx_q + 1'b1;
            state_q <= StSymChk;
          end
        end
        StFin: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  // Pixel bus: forward whichever engine is being waited on, one cycle late.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x_q      <= '0;
      y_q      <= '0;
      colour_q <= '0;
      plot_q   <= 1'b0;
    end else if (state_q == StCardWait) begin
      x_q      <= card_x;
      y_q      <= card_y;
      colour_q <= card_colour;
      plot_q   <= card_we;
    end else if (state_q == StSymWait) begin
      x_q      <= px_x;
      y_q      <= px_y;
      colour_q <= px_colour;
      plot_q   <= px_we;
    end else begin
      x_q      <= '0;
      y_q      <= '0;
      colour_q <= '0;
      plot_q   <= 1'b0;
    end
  end

  assign card_start = card_start_q;
  assign sym_start  = sym_start_q;
  assign sym_sel    = sym_sel_q;
  assign sym_x      = sym_x_q;
  assign sym_y      = sym_y_q;
  assign done       = done_q;
  assign error      = error_q;
  assign x          = x_q;
  assign y          = y_q;
  assign colour     = colour_q;
  assign plot       = plot_q;
  assign busy       = (state_q != StIdle);

endmodule
